// File: rtl/imm_pkg.sv
// Shared types for the immediate generator.
//   imm_src_t   : 3-bit immediate-format select driven by the decoder control.
//   imm_entry_t : one output-queue record. The fields are sized for the widest
//                 supported datapath (64 bits); a 32-bit build fills only the low
//                 half, and the constant-zero upper bits are optimised away.
// Optional macro IMM_TARGET_EN adds the branch/jump target field.
package imm_pkg;

  localparam int IMM_SRC_W    = 3;
  localparam int IMM_XLEN_MAX = 64;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_J     = 3'd3,
    IMM_U     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_ZIMM  = 3'd6,
    IMM_RSVD  = 3'd7
  } imm_src_t;

  typedef struct packed {
    logic [IMM_XLEN_MAX-1:0] imm;
    logic                    illegal;
`ifdef IMM_TARGET_EN
    logic [IMM_XLEN_MAX-1:0] target;
`endif
  } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode.
//   instr   : 32-bit instruction word
//   imm_src : format select
//   imm     : immediate extended to XLEN
//   illegal : set for the reserved format (immediate then decoded as I-type)
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_src_t        imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // A size cast of a signed operand replicates its sign bit, so this covers
  // both XLEN=32 (no-op) and XLEN=64 (sign fill) without a zero-width replicate.
  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    logic signed [XLEN-1:0] w;
    w = XLEN'(v);
    return w;
  endfunction

  logic signed [31:0] simm;
  logic [5:0]         uimm;
  logic               is_zext;

  always_comb begin
    simm    = {{20{instr[31]}}, instr[31:20]};
    uimm    = '0;
    is_zext = 1'b0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I:     simm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:     simm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     simm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:     simm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:     simm = {instr[31:12], 12'b0};
      IMM_SHAMT: begin
        is_zext = 1'b1;
        uimm    = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
      end
      IMM_ZIMM: begin
        is_zext = 1'b1;
        uimm    = {1'b0, instr[19:15]};
      end
      default:   illegal = 1'b1;
    endcase
    imm = is_zext ? XLEN'(uimm) : sext32(simm);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with an in-order output queue.
// The instruction is decoded on push and the result is held in a circular
// queue; outputs are driven from the head entry only, and in_ready depends
// only on the registered count, so downstream stalls never reach fetch
// combinationally.
//   clk, rst (sync, active-high), flush (sync queue clear)
//   in_valid/in_ready, in_instr[31:0], in_imm_src[2:0]  : upstream handshake
//   out_valid/out_ready, out_imm[XLEN-1:0], out_illegal : head entry
// Optional macro IMM_TARGET_EN adds in_pc[XLEN-1:0] and out_target[XLEN-1:0]
// (in_pc + imm, modulo 2^XLEN, captured at push).
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  imm_src_t        in_imm_src,
`ifdef IMM_TARGET_EN
  input  logic [XLEN-1:0] in_pc,
  output logic [XLEN-1:0] out_target,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [XLEN-1:0]  dec_imm_p0;
  logic             dec_illegal_p0;
  imm_entry_t       entry_p0;
  imm_entry_t       mem_p1 [DEPTH];
  imm_entry_t       head_p1;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             vld_p1;

  // ---- stage p0: decode at the input handshake ----
  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm_src (in_imm_src),
    .imm     (dec_imm_p0),
    .illegal (dec_illegal_p0)
  );

  always_comb begin
    entry_p0         = '0;
    entry_p0.imm     = IMM_XLEN_MAX'(dec_imm_p0);
    entry_p0.illegal = dec_illegal_p0;
`ifdef IMM_TARGET_EN
    entry_p0.target  = IMM_XLEN_MAX'(in_pc + dec_imm_p0);
`endif
  end

  assign in_ready = (count < CNT_W'(DEPTH));
  assign vld_p1   = (count != '0);
  assign push     = in_valid && in_ready;
  assign pop      = vld_p1 && out_ready;

  // ---- stage p1: output queue ----
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem_p1[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem_p1[wr_ptr] <= entry_p0;
        wr_ptr         <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stale head contents are masked so an empty queue always shows zeros.
  assign head_p1     = mem_p1[rd_ptr];
  assign out_valid   = vld_p1;
  assign out_imm     = vld_p1 ? head_p1.imm[XLEN-1:0] : '0;
  assign out_illegal = vld_p1 & head_p1.illegal;
`ifdef IMM_TARGET_EN
  assign out_target  = vld_p1 ? head_p1.target[XLEN-1:0] : '0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit and a 64-bit instance share stimulus.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  imm_src_t    in_imm_src;
  logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
`ifdef IMM_TARGET_EN
  logic [31:0] pc32, tgt32;
  logic [63:0] pc64, tgt64;
`endif

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_imm_src(in_imm_src),
`ifdef IMM_TARGET_EN
    .in_pc(pc32), .out_target(tgt32),
`endif
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_imm_src(in_imm_src),
`ifdef IMM_TARGET_EN
    .in_pc(pc64), .out_target(tgt64),
`endif
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_illegal(ill64)
  );

  typedef struct {
    logic [63:0] imm;
    logic        ill;
    logic [63:0] tgt;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    imm_src_t    src;
    logic [63:0] e32;
    logic [63:0] e64;
    logic        ill;
  } vec_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Holds in_valid until both instances accept (bounded), then records the
  // expected head contents for the scoreboard.
  task automatic push(input logic [31:0] instr, input imm_src_t src,
                      input logic [63:0] e32, input logic [63:0] e64, input logic ill);
    bit   done;
    exp_t x;
    done       = 1'b0;
    in_instr   = instr;
    in_imm_src = src;
    in_valid   = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (rdy32 && rdy64) begin
        done  = 1'b1;
        x.ill = ill;
        x.imm = {32'h0, e32[31:0]};
        x.tgt = 64'h0;
`ifdef IMM_TARGET_EN
        x.tgt = {32'h0, pc32 + e32[31:0]};
`endif
        q32.push_back(x);
        x.imm = e64;
`ifdef IMM_TARGET_EN
        x.tgt = pc64 + e64;
`endif
        q64.push_back(x);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: got in_ready=0 expected acceptance of %h", instr);
    end
  endtask

  vec_t vecs[13];

  initial begin
    vecs = '{
      '{32'hFFF00093, IMM_I,     64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0},
      '{32'hFE000EE3, IMM_B,     64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0},
      '{32'h7FF00093, IMM_I,     64'h000007FF, 64'h00000000000007FF, 1'b0},
      '{32'h00A12423, IMM_S,     64'h00000008, 64'h0000000000000008, 1'b0},
      '{32'hFE112E23, IMM_S,     64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0},
      '{32'h008000EF, IMM_J,     64'h00000008, 64'h0000000000000008, 1'b0},
      '{32'hFF9FF0EF, IMM_J,     64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0},
      '{32'h12345037, IMM_U,     64'h12345000, 64'h0000000012345000, 1'b0},
      '{32'h800002B7, IMM_U,     64'h80000000, 64'hFFFFFFFF80000000, 1'b0},
      '{32'h43F0D093, IMM_SHAMT, 64'h0000001F, 64'h000000000000003F, 1'b0},
      '{32'hFC0FD073, IMM_ZIMM,  64'h0000001F, 64'h000000000000001F, 1'b0},
      '{32'h00100093, IMM_RSVD,  64'h00000001, 64'h0000000000000001, 1'b1},
      '{32'hFFF00093, IMM_RSVD,  64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1}
    };

    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b1;
    in_instr   = 32'hFFF00093;
    in_imm_src = IMM_I;
    out_ready  = 1'b1;
`ifdef IMM_TARGET_EN
    pc32 = '0;
    pc64 = '0;
`endif

    // Scoreboard: every head consumed is compared against the oldest expectation.
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (vld32 && out_ready) begin
            if (q32.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL unexpected32: got imm %h expected no output", imm32);
            end else begin
              e = q32.pop_front();
              chk("imm32", {32'h0, imm32}, e.imm);
              chk("ill32", {63'h0, ill32}, {63'h0, e.ill});
`ifdef IMM_TARGET_EN
              chk("tgt32", {32'h0, tgt32}, e.tgt);
`endif
            end
          end
          if (vld64 && out_ready) begin
            if (q64.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL unexpected64: got imm %h expected no output", imm64);
            end else begin
              e = q64.pop_front();
              chk("imm64", imm64, e.imm);
              chk("ill64", {63'h0, ill64}, {63'h0, e.ill});
`ifdef IMM_TARGET_EN
              chk("tgt64", tgt64, e.tgt);
`endif
            end
          end
        end
      end
    join_none

    // Reset held two cycles with in_valid high: nothing captured.
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready32", {63'h0, rdy32}, 64'h1);
    chk("rst_valid32", {63'h0, vld32}, 64'h0);
    chk("rst_imm32",   {32'h0, imm32}, 64'h0);
    chk("rst_valid64", {63'h0, vld64}, 64'h0);
    chk("rst_imm64",   imm64, 64'h0);
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid32", {63'h0, vld32}, 64'h0);

    // Format table, streaming with the consumer always ready.
    @(posedge clk); #1;
    foreach (vecs[i]) push(vecs[i].instr, vecs[i].src, vecs[i].e32, vecs[i].e64, vecs[i].ill);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: A and B fill the queue, C waits until a pop frees a slot.
    out_ready = 1'b0;
    push(32'h00A12423, IMM_S, 64'h8, 64'h8, 1'b0);
    push(32'hFFF00093, IMM_I, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    fork
      push(32'h12345037, IMM_U, 64'h12345000, 64'h12345000, 1'b0);
      begin
        @(negedge clk);
        chk("full_ready32", {63'h0, rdy32}, 64'h0);
        chk("stall_head32", {32'h0, imm32}, 64'h8);
        @(negedge clk);
        chk("full_ready64", {63'h0, rdy64}, 64'h0);
        chk("stall_head64", imm64, 64'h8);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Flush with one entry queued and a same-cycle push: both disappear.
    out_ready = 1'b0;
    push(32'h7FF00093, IMM_I, 64'h7FF, 64'h7FF, 1'b0);
    flush      = 1'b1;
    in_valid   = 1'b1;
    in_instr   = 32'hFFF00093;
    in_imm_src = IMM_I;
    @(negedge clk);
    chk("flush_ready32", {63'h0, rdy32}, 64'h1);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q32.delete();
    q64.delete();
    @(negedge clk);
    chk("flush1_valid32", {63'h0, vld32}, 64'h0);
    chk("flush1_valid64", {63'h0, vld64}, 64'h0);

    // Flush with the queue full and a push offered.
    @(posedge clk); #1;
    push(32'h00A12423, IMM_S, 64'h8, 64'h8, 1'b0);
    push(32'h008000EF, IMM_J, 64'h8, 64'h8, 1'b0);
    flush      = 1'b1;
    in_valid   = 1'b1;
    in_instr   = 32'h800002B7;
    in_imm_src = IMM_U;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q32.delete();
    q64.delete();
    @(negedge clk);
    chk("flush2_valid32", {63'h0, vld32}, 64'h0);
    chk("flush2_ready32", {63'h0, rdy32}, 64'h1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(32'h00100093, IMM_RSVD, 64'h1, 64'h1, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-stream drops the queued entry; the next push is normal.
    out_ready = 1'b0;
    push(32'hFE000EE3, IMM_B, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q32.delete();
    q64.delete();
    @(negedge clk);
    chk("midrst_valid32", {63'h0, vld32}, 64'h0);
    chk("midrst_imm64",   imm64, 64'h0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(32'h00A12423, IMM_S, 64'h8, 64'h8, 1'b0);
    repeat (2) @(posedge clk);
    #1;

`ifdef IMM_TARGET_EN
    out_ready = 1'b0;
    pc32 = 32'h00001000;
    pc64 = 64'h0000000000001000;
    push(32'hFE000EE3, IMM_B, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    @(negedge clk);
    chk("target_b32", {32'h0, tgt32}, 64'h00000FFC);
    chk("target_b64", tgt64, 64'h0000000000000FFC);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    pc32 = 32'hFFFFFFFC;
    pc64 = 64'hFFFFFFFFFFFFFFFC;
    push(32'h008000EF, IMM_J, 64'h8, 64'h8, 1'b0);
    @(negedge clk);
    chk("target_wrap32", {32'h0, tgt32}, 64'h4);
    chk("target_wrap64", tgt64, 64'h4);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pc32 = '0;
    pc64 = '0;
`endif

    // Every expected result must have been produced.
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (q32.size() != 0 || q64.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk("drain32", 64'(q32.size()), 64'h0);
    chk("drain64", 64'(q64.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
